// File: rtl/pc_seq_pkg.sv
// Shared types and default sizing for the program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int unsigned PC_W    = 10;
  localparam int unsigned STACK_D = 4;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO: DEPTH entries of D bits, push/pop guarded by full/empty.
module ret_stack
  import pc_seq_pkg::*;
#(
  parameter int unsigned D     = PC_W,
  parameter int unsigned DEPTH = STACK_D
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [D-1:0] din,
  output logic [D-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int unsigned SPW = $clog2(DEPTH + 1);
  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [D-1:0]   mem [DEPTH];
  logic [SPW-1:0] sp;
  logic [SPW-1:0] sp_dec;
  logic [AW-1:0]  wr_idx;
  logic [AW-1:0]  rd_idx;

  assign sp_dec = sp - SPW'(1);
  assign wr_idx = sp[AW-1:0];
  assign rd_idx = sp_dec[AW-1:0];
  assign full   = (sp == SPW'(DEPTH));
  assign empty  = (sp == '0);
  assign top    = mem[rd_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp <= '0;
    end else if (clear) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SPW'(1);
    end else if (pop && !empty) begin
      sp <= sp_dec;
    end
  end

  // Storage needs no reset: entries above sp are never observed.
  always_ff @(posedge clk) begin
    if (push && !full && !clear) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/HALT control with branch, call and return.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned D           = PC_W,
  parameter int unsigned STACK_DEPTH = STACK_D
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stall,
  input  logic         halt_req,
  input  logic         branch_en,
  input  logic         branch_taken,
  input  logic         rel_mode,
  input  logic         call_en,
  input  logic         ret_en,
  input  logic [3:0]   target_idx,
  output logic [3:0]   lut_addr,
  input  logic [D-1:0] lut_target,
  output logic [D-1:0] pc,
  output logic         running,
  output logic         done,
  output logic         err
);

  state_t       state, state_n;
  logic [D-1:0] pc_n;
  logic         err_n;
  logic         stk_push, stk_pop, stk_clr;
  logic [D-1:0] stk_top;
  logic         stk_full, stk_empty;
  logic [D-1:0] pc_inc;

  assign lut_addr = target_idx;
  assign running  = (state == RUN);
  assign done     = (state == HALT);
  assign pc_inc   = pc + D'(1);

  ret_stack #(
    .D     (D),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .clear (stk_clr),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (pc_inc),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc    <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      err   <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    err_n    = err;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_clr  = 1'b0;
    unique case (state)
      RUN: begin
        if (halt_req) begin
          state_n = HALT;
        end else if (stall) begin
          pc_n = pc;
        end else if (ret_en) begin
          if (stk_empty) begin
            err_n   = 1'b1;
            state_n = HALT;
          end else begin
            stk_pop = 1'b1;
            pc_n    = stk_top;
          end
        end else if (call_en) begin
          if (stk_full) begin
            err_n   = 1'b1;
            state_n = HALT;
          end else begin
            stk_push = 1'b1;
            pc_n     = lut_target;
          end
        end else if (branch_en && branch_taken) begin
          // Modular D-bit add gives two's-complement relative jumps for free.
          pc_n = rel_mode ? (pc + lut_target) : lut_target;
        end else begin
          pc_n = pc_inc;
        end
      end
      IDLE, HALT: begin
        if (start) begin
          state_n = RUN;
          pc_n    = '0;
          err_n   = 1'b0;
          stk_clr = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        pc_n    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios then random traffic vs a queue-based model.
module tb_pc_sequencer;

  localparam int D   = 10;
  localparam int MOD = 1 << D;
  localparam int SD  = 4;

  logic         clk, reset, start, stall, halt_req, branch_en, branch_taken;
  logic         rel_mode, call_en, ret_en;
  logic [3:0]   target_idx, lut_addr;
  logic [D-1:0] lut_target, pc;
  logic         running, done, err;
  logic [D-1:0] lut [16];

  int unsigned n_checks, n_pass;
  int          m_pc;
  bit          m_run, m_done, m_err;
  int          m_stk[$];

  assign lut_target = lut[lut_addr];

  pc_sequencer #(
    .D           (D),
    .STACK_DEPTH (SD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stall        (stall),
    .halt_req     (halt_req),
    .branch_en    (branch_en),
    .branch_taken (branch_taken),
    .rel_mode     (rel_mode),
    .call_en      (call_en),
    .ret_en       (ret_en),
    .target_idx   (target_idx),
    .lut_addr     (lut_addr),
    .lut_target   (lut_target),
    .pc           (pc),
    .running      (running),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"}, 32'(pc), 32'(m_pc));
    check({tag, ".running"}, 32'(running), 32'(m_run));
    check({tag, ".done"}, 32'(done), 32'(m_done));
    check({tag, ".err"}, 32'(err), 32'(m_err));
    check({tag, ".lut_addr"}, 32'(lut_addr), 32'(target_idx));
  endtask

  task automatic idle_inputs();
    start = 0; stall = 0; halt_req = 0; branch_en = 0; branch_taken = 0;
    rel_mode = 0; call_en = 0; ret_en = 0; target_idx = 4'd0;
  endtask

  task automatic model_reset();
    m_pc = 0; m_run = 0; m_done = 0; m_err = 0;
    m_stk.delete();
  endtask

  function automatic int signed_of(input int v);
    return (v >= MOD / 2) ? v - MOD : v;
  endfunction

  task automatic model_step();
    int tgt;
    tgt = int'(lut[target_idx]);
    if (!m_run) begin
      if (start) begin
        m_run = 1; m_done = 0; m_pc = 0; m_err = 0;
        m_stk.delete();
      end
    end else if (halt_req) begin
      m_run = 0; m_done = 1;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (ret_en) begin
      if (m_stk.size() == 0) begin
        m_err = 1; m_run = 0; m_done = 1;
      end else begin
        m_pc = m_stk.pop_back();
      end
    end else if (call_en) begin
      if (m_stk.size() == SD) begin
        m_err = 1; m_run = 0; m_done = 1;
      end else begin
        m_stk.push_back((m_pc + 1) % MOD);
        m_pc = tgt;
      end
    end else if (branch_en && branch_taken) begin
      if (rel_mode) m_pc = (m_pc + signed_of(tgt) + MOD) % MOD;
      else          m_pc = tgt;
    end else begin
      m_pc = (m_pc + 1) % MOD;
    end
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 16; i++) lut[i] = '0;
    idle_inputs();
    reset = 1'b1;
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("idle_hold");

    // start, then three plain cycles: 0,1,2,3
    start = 1; step("start");
    start = 0;
    for (int i = 1; i <= 3; i++) step("seq");
    step("to4");

    // relative branch of -5 from pc 4 wraps to 1023, then to 0
    lut[1] = 10'h3FB;
    target_idx = 4'd1; branch_en = 1; branch_taken = 1; rel_mode = 1;
    step("rel_neg");
    idle_inputs();
    step("wrap");

    // jump to 7, call 80, two increments, return to 8
    lut[2] = 10'd7; lut[3] = 10'd80;
    target_idx = 4'd2; branch_en = 1; branch_taken = 1;
    step("abs_to7");
    idle_inputs(); target_idx = 4'd3; call_en = 1;
    step("call80");
    idle_inputs();
    step("inc81");
    step("inc82");
    ret_en = 1;
    step("ret8");
    idle_inputs();

    // four nested calls fill the stack; the fifth overflows
    lut[4] = 10'd100;
    target_idx = 4'd4; call_en = 1;
    for (int i = 0; i < 4; i++) step("nest");
    step("overflow");
    idle_inputs();
    step("halt_hold");
    start = 1; step("restart");
    idle_inputs();

    // stall beats a taken branch; halt beats a return
    target_idx = 4'd2; branch_en = 1; branch_taken = 1; stall = 1;
    step("stall_br");
    idle_inputs(); target_idx = 4'd3; call_en = 1;
    step("call_again");
    idle_inputs(); halt_req = 1; ret_en = 1;
    step("halt_ret");
    idle_inputs();
    step("halted");
    // running bit clear while halted ignores a stale 'start' not asserted
    ret_en = 1; step("halted_ret_ignored");
    idle_inputs();

    // ret on an empty stack
    start = 1; step("restart2");
    start = 0; ret_en = 1;
    step("underflow");
    idle_inputs();

    // start while running is ignored
    start = 1; step("restart3");
    step("start_in_run");
    idle_inputs();

    // asynchronous reset mid-cycle at pc 50
    lut[6] = 10'd50;
    target_idx = 4'd6; branch_en = 1; branch_taken = 1;
    step("abs_to50");
    idle_inputs();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("await_start");

    // random traffic
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 3) == 0) lut[$urandom_range(0, 15)] = D'($urandom);
      start        = (!m_run && $urandom_range(0, 2) == 0) || ($urandom_range(0, 39) == 0);
      halt_req     = ($urandom_range(0, 29) == 0);
      stall        = ($urandom_range(0, 5) == 0);
      ret_en       = ($urandom_range(0, 4) == 0);
      call_en      = ($urandom_range(0, 5) == 0);
      branch_en    = ($urandom_range(0, 2) == 0);
      branch_taken = $urandom_range(0, 1) == 1;
      rel_mode     = $urandom_range(0, 1) == 1;
      target_idx   = 4'($urandom_range(0, 15));
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The module SHALL have parameter D, default 10, meaning program-counter width in bits.
REQ-002 The module SHALL have parameter STACK_DEPTH, default 4, meaning return-stack entries.
REQ-003 The module SHALL have port clk, input, width 1: the single clock; all state updates occur on its rising edge.
REQ-004 The module SHALL have port reset, input, width 1: asynchronous, active-high reset.
REQ-005 The module SHALL have port start, input, width 1: pulse that begins or restarts execution at PC 0.
REQ-006 The module SHALL have port stall, input, width 1: hold the PC this cycle.
REQ-007 The module SHALL have port halt_req, input, width 1: the program requests termination.
REQ-008 The module SHALL have port branch_en, input, width 1: the current instruction is a branch.
REQ-009 The module SHALL have port branch_taken, input, width 1: the branch condition is true.
REQ-010 The module SHALL have port rel_mode, input, width 1: the LUT target is a signed offset (1) or an absolute address (0).
REQ-011 The module SHALL have port call_en, input, width 1: call through a LUT target.
REQ-012 The module SHALL have port ret_en, input, width 1: return to the popped address.
REQ-013 The module SHALL have port target_idx, input, width 4: branch/call LUT index.
REQ-014 The module SHALL have port lut_addr, output, width 4: address to the branch-target LUT, combinationally equal to target_idx.
REQ-015 The module SHALL have port lut_target, input, width D: combinational LUT read data.
REQ-016 The module SHALL have port pc, output, width D: current program counter.
REQ-017 The module SHALL have port running, output, width 1: 1 while in state RUN.
REQ-018 The module SHALL have port done, output, width 1: 1 while in state HALT.
REQ-019 The module SHALL have port err, output, width 1: sticky stack overflow/underflow flag.

Function
REQ-020 The FSM SHALL have states IDLE, RUN and HALT; IDLE and HALT hold pc, and start in either state SHALL go to RUN with pc=0, stack empty and err=0 on the next edge.
REQ-021 In RUN, each cycle SHALL take exactly one action in strict priority: halt_req > stall > ret_en > call_en > (branch_en and branch_taken) > increment.
REQ-022 halt_req SHALL move the FSM to HALT with pc unchanged.
REQ-023 stall SHALL hold pc and the stack, discarding any branch/call/ret that cycle; the requester re-presents it.
REQ-024 ret_en with a non-empty stack SHALL pop and load pc with the popped value; on an empty stack it SHALL set err, go to HALT and leave pc unchanged.
REQ-025 call_en with a non-full stack SHALL push (pc+1) mod 2^D and load pc=lut_target (always absolute); on a full stack it SHALL set err, go to HALT, and leave pc and the stack unchanged.
REQ-026 A taken branch SHALL load pc=lut_target when rel_mode=0, and pc=(pc+lut_target) mod 2^D with lut_target as two's complement when rel_mode=1.
REQ-027 The default action SHALL be pc=(pc+1) mod 2^D, wrapping from 2^D-1 to 0 without error.
REQ-028 Every decision SHALL be combinational on same-cycle inputs; the new pc SHALL be visible one edge later (latency 1).
REQ-029 start asserted while in RUN SHALL be ignored.

Reset
REQ-030 Asserting reset SHALL immediately force state IDLE, pc=0, stack pointer=0, err=0, running=0 and done=0, independent of clk.
REQ-031 Reset asserted mid-operation SHALL discard any in-flight action, and after deassertion the block SHALL await start.

Structure
REQ-032 A shared package pc_seq_pkg SHALL hold the state enum (IDLE/RUN/HALT) and the default PC width and stack-depth constants.
REQ-033 The return stack SHALL be a separate sub-module ret_stack: a STACK_DEPTH x D LIFO with push, pop, full, empty and top outputs, and async reset.

Verification
REQ-034 The bench SHALL check: reset, then start, then 3 idle cycles -> pc sequence 0,1,2,3 with running=1.
REQ-035 The bench SHALL check: at pc=4 with rel_mode=1, a taken branch with lut_target=0x3FB (-5) -> pc=1023; the next cycle pc=0 (wrap).
REQ-036 The bench SHALL check: at pc=7, call with lut_target=80 -> pc=80; 2 increments, then ret_en -> pc=8.
REQ-037 The bench SHALL check: 4 nested calls, then a 5th call -> err=1, done=1, pc unchanged; start -> pc=0, err=0.
REQ-038 The bench SHALL check: stall together with a taken branch -> pc holds; halt_req together with ret_en -> HALT and the stack is not popped.
REQ-039 The bench SHALL check: reset asserted between clock edges while in RUN at pc=50 -> pc=0 and state IDLE immediately, without waiting for a clock edge.
